// File: rtl/arbitrated_multiplexer_pkg.sv
// Shared types and helpers for the arbitrated stream multiplexer.
package arbitrated_multiplexer_pkg;

    // Arbiter state: IDLE re-arbitrates each beat, LOCKED holds one channel
    // until the packet's last beat is accepted.
    typedef enum logic {
        MUX_IDLE,
        MUX_LOCKED
    } mux_state_t;

    // Channel index + 1 with an explicit wrap, so non-power-of-two channel
    // counts return to 0 after the highest channel.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arbitrated_multiplexer_rr_picker.sv
// Rotating-priority picker: the first requesting channel at or above ptr,
// wrapping modulo CHANNELS, wins. Purely combinational.
module rr_picker #(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);

    // cand_idx[k] is the channel examined at priority k (k=0 highest).
    // ptr is always below CHANNELS, so a single subtraction wraps it.
    logic [SEL_W-1:0] cand_idx [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cand
            assign cand_idx[gi] = (int'(ptr) + gi >= CHANNELS)
                                ? SEL_W'(int'(ptr) + gi - CHANNELS)
                                : SEL_W'(int'(ptr) + gi);
        end
    endgenerate

    // Scan from lowest priority to highest so the highest-priority hit wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                grant       = cand_idx[k];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplexer.sv
// Plain N-to-1 data selector. Channel 0 occupies the most significant slice
// of in_bus. An out-of-range sel yields zero.
module multiplexer #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out
);

    logic [WIDTH-1:0] slice [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slice
            assign slice[gi] = in_bus[(CHANNELS-gi)*WIDTH-1 -: WIDTH];
        end
    endgenerate

    // Select the slice whose index matches sel.
    always_comb begin
        out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel == SEL_W'(c)) begin
                out = slice[c];
            end
        end
    end

endmodule

// File: rtl/arbitrated_multiplexer.sv
// N-channel stream multiplexer with a registered output stage, per-channel
// valid/ready handshakes and packet-locked round-robin arbitration with an
// optional forced-select override.
module arbitrated_multiplexer
    import arbitrated_multiplexer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [SEL_W-1:0]          out_channel,
    input  logic                      out_ready
);

    mux_state_t       state_reg;
    logic [SEL_W-1:0] ptr_reg;
    logic [SEL_W-1:0] lock_ch_reg;
    logic             pkt_rr_reg;   // current locked packet began under round-robin
    logic [WIDTH-1:0] out_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic [SEL_W-1:0] out_channel_reg;

    logic [SEL_W-1:0] rr_grant;
    logic             rr_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             grant_last;
    logic             load_ok;
    logic             accept;
    logic [SEL_W-1:0] ptr_next;
    logic [WIDTH-1:0] mux_data;

    rr_picker #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_picker (
        .req         (in_valid),
        .ptr         (ptr_reg),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    multiplexer #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_mux (
        .in_bus (in_bus),
        .sel    (grant),
        .out    (mux_data)
    );

    // Arbitration: locked packets own the output; otherwise force or round-robin.
    // Index lookups are loop compares so an out-of-range force_sel simply misses.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_last  = 1'b0;
        if (state_reg == MUX_LOCKED) begin
            grant = lock_ch_reg;
            for (int c = 0; c < CHANNELS; c++) begin
                if (lock_ch_reg == SEL_W'(c) && in_valid[c]) begin
                    grant_valid = 1'b1;
                end
            end
        end else if (force_en) begin
            grant = force_sel;
            for (int c = 0; c < CHANNELS; c++) begin
                if (force_sel == SEL_W'(c) && in_valid[c]) begin
                    grant_valid = 1'b1;
                end
            end
        end else begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant == SEL_W'(c)) begin
                grant_last = in_last[c];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign load_ok  = !out_valid_reg || out_ready;
    assign accept   = grant_valid && load_ok && !reset;
    assign ptr_next = SEL_W'(wrap_inc(int'(grant), CHANNELS));

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign in_ready[gi] = accept && (grant == SEL_W'(gi));
        end
    endgenerate

    // FSM, round-robin pointer and output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= MUX_IDLE;
            ptr_reg         <= '0;
            lock_ch_reg     <= '0;
            pkt_rr_reg      <= 1'b0;
            out_reg         <= '0;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
            out_channel_reg <= '0;
        end else begin
            if (accept) begin
                out_reg         <= mux_data;
                out_last_reg    <= grant_last;
                out_channel_reg <= grant;
                out_valid_reg   <= 1'b1;
                case (state_reg)
                    MUX_IDLE: begin
                        if (!grant_last) begin
                            state_reg   <= MUX_LOCKED;
                            lock_ch_reg <= grant;
                            pkt_rr_reg  <= !force_en;
                        end else if (!force_en) begin
                            ptr_reg <= ptr_next;
                        end
                    end
                    MUX_LOCKED: begin
                        if (grant_last) begin
                            state_reg <= MUX_IDLE;
                            if (pkt_rr_reg) begin
                                ptr_reg <= ptr_next;
                            end
                        end
                    end
                    default: state_reg <= MUX_IDLE;
                endcase
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out         = out_reg;
    assign out_valid   = out_valid_reg;
    assign out_last    = out_last_reg;
    assign out_channel = out_channel_reg;

endmodule

// File: tb/tb_arbitrated_multiplexer.sv
// Bench for arbitrated_multiplexer: an 8-channel instance checked by a table
// and by randomized traffic against a behavioural model, plus a 5-channel
// instance for the out-of-range force and wrap/reset sequences.
module tb_arbitrated_multiplexer;

    localparam int W  = 32;
    localparam int NA = 8;
    localparam int NB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int misc    = 0;

    // ---------------- 8-channel instance ----------------
    logic            a_rst;
    logic [NA*W-1:0] a_in_bus;
    logic [W-1:0]    a_data [NA];
    logic [NA-1:0]   a_valid, a_last, a_ready;
    logic            a_fen;
    logic [2:0]      a_fsel;
    logic [W-1:0]    a_out;
    logic            a_ov, a_ol, a_ordy;
    logic [2:0]      a_oc;

    always_comb begin
        a_in_bus = '0;
        for (int i = 0; i < NA; i++) a_in_bus[(NA-i)*W-1 -: W] = a_data[i];
    end

    arbitrated_multiplexer #(.WIDTH(W), .CHANNELS(NA)) dut_a (
        .clock(clk), .reset(a_rst), .in_bus(a_in_bus), .in_valid(a_valid),
        .in_last(a_last), .in_ready(a_ready), .force_en(a_fen), .force_sel(a_fsel),
        .out(a_out), .out_valid(a_ov), .out_last(a_ol), .out_channel(a_oc),
        .out_ready(a_ordy)
    );

    // ---------------- 5-channel instance ----------------
    logic            b_rst;
    logic [NB*W-1:0] b_in_bus;
    logic [W-1:0]    b_data [NB];
    logic [NB-1:0]   b_valid, b_last, b_ready;
    logic            b_fen;
    logic [2:0]      b_fsel;
    logic [W-1:0]    b_out;
    logic            b_ov, b_ol, b_ordy;
    logic [2:0]      b_oc;

    always_comb begin
        b_in_bus = '0;
        for (int i = 0; i < NB; i++) b_in_bus[(NB-i)*W-1 -: W] = b_data[i];
    end

    arbitrated_multiplexer #(.WIDTH(W), .CHANNELS(NB)) dut_b (
        .clock(clk), .reset(b_rst), .in_bus(b_in_bus), .in_valid(b_valid),
        .in_last(b_last), .in_ready(b_ready), .force_en(b_fen), .force_sel(b_fsel),
        .out(b_out), .out_valid(b_ov), .out_last(b_ol), .out_channel(b_oc),
        .out_ready(b_ordy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the 8-channel instance ----------------
    bit          m_locked, m_rr, m_ov, m_ol, m_acc;
    int          m_lock, m_ptr, m_oc;
    logic [31:0] m_od;

    task automatic model_grant(output int g, output bit gv);
        g  = 0;
        gv = 0;
        if (m_locked) begin
            g  = m_lock;
            gv = a_valid[g];
        end else if (a_fen) begin
            g  = int'(a_fsel);
            gv = (g < NA) && a_valid[g];
        end else begin
            for (int k = 0; k < NA; k++) begin
                int idx;
                idx = (m_ptr + k) % NA;
                if (!gv && a_valid[idx]) begin
                    gv = 1;
                    g  = idx;
                end
            end
        end
    endtask

    task automatic model_ready(output logic [7:0] rdy);
        int g;
        bit gv;
        model_grant(g, gv);
        rdy = (gv && (!m_ov || a_ordy) && !a_rst) ? 8'(1 << g) : 8'h00;
    endtask

    task automatic model_edge();
        int g;
        bit gv;
        bit lb;
        m_acc = 0;
        if (a_rst) begin
            m_locked = 0; m_rr = 0; m_lock = 0; m_ptr = 0;
            m_ov = 0; m_ol = 0; m_oc = 0; m_od = 0;
            return;
        end
        model_grant(g, gv);
        if (gv && (!m_ov || a_ordy)) begin
            m_acc = 1;
            lb    = a_last[g];
            m_od  = a_data[g];
            m_ol  = lb;
            m_oc  = g;
            m_ov  = 1;
            if (!m_locked) begin
                if (!lb) begin
                    m_locked = 1;
                    m_lock   = g;
                    m_rr     = !a_fen;
                end else if (!a_fen) begin
                    m_ptr = (g + 1) % NA;
                end
            end else if (lb) begin
                m_locked = 0;
                if (m_rr) m_ptr = (g + 1) % NA;
            end
        end else if (m_ov && a_ordy) begin
            m_ov = 0;
        end
    endtask

    // One clock of the 8-channel instance: in_ready checked before the edge,
    // registered outputs checked just after it; optional table expectations.
    task automatic tick_a(input bit tbl, input logic [7:0] e_rdy, input bit e_ov,
                          input int e_oc, input logic [31:0] e_od);
        logic [7:0] rdy;
        @(negedge clk);
        model_ready(rdy);
        check("a_in_ready_model", 64'(a_ready), 64'(rdy));
        if (tbl) check("a_in_ready_table", 64'(a_ready), 64'(e_rdy));
        model_edge();
        @(posedge clk);
        #1;
        check("a_out_valid_model", 64'(a_ov), 64'(m_ov));
        check("a_out_channel_model", 64'(a_oc), 64'(m_oc));
        check("a_out_last_model", 64'(a_ol), 64'(m_ol));
        check("a_out_data_model", 64'(a_out), 64'(m_od));
        if (tbl) begin
            check("a_out_valid_table", 64'(a_ov), 64'(e_ov));
            check("a_out_channel_table", 64'(a_oc), 64'(e_oc));
            check("a_out_data_table", 64'(a_out), 64'(e_od));
        end
        if (m_acc) $display("beat a ch=%0d data=%08h last=%0b", m_oc, m_od, m_ol);
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] valid;
        logic [7:0] last;
        logic       fen;
        logic [2:0] fsel;
        logic       ordy;
        logic [7:0] rdy;
        logic       ov;
        int         oc;
    } vec_t;

    vec_t tq[$];

    task automatic add(input logic rst, input logic [7:0] v, input logic [7:0] l,
                       input logic fen, input logic [2:0] fsel, input logic ordy,
                       input logic [7:0] rdy, input logic ov, input int oc);
        vec_t r;
        r = '{rst, v, l, fen, fsel, ordy, rdy, ov, oc};
        tq.push_back(r);
    endtask

    // One clock of the 5-channel instance against hand-derived expectations.
    task automatic tick_b(input logic rst, input logic [4:0] v, input logic [4:0] l,
                          input logic fen, input logic [2:0] fsel, input logic [4:0] e_rdy,
                          input logic e_ov, input int e_oc, input bit zero_out);
        logic [31:0] e_od;
        b_rst = rst; b_valid = v; b_last = l; b_fen = fen; b_fsel = fsel; b_ordy = 1'b1;
        @(negedge clk);
        check("b_in_ready", 64'(b_ready), 64'(e_rdy));
        @(posedge clk);
        #1;
        e_od = zero_out ? 32'h0 : 32'h200 + 32'(e_oc);
        check("b_out_valid", 64'(b_ov), 64'(e_ov));
        check("b_out_channel", 64'(b_oc), 64'(e_oc));
        check("b_out_data", 64'(b_out), 64'(e_od));
        if (b_ov) $display("beat b ch=%0d data=%08h last=%0b", b_oc, b_out, b_ol);
    endtask

    initial begin
        a_rst = 1; a_valid = '0; a_last = '0; a_fen = 0; a_fsel = '0; a_ordy = 1;
        b_rst = 1; b_valid = '0; b_last = '0; b_fen = 0; b_fsel = '0; b_ordy = 1;
        for (int i = 0; i < NA; i++) a_data[i] = 32'h100 + 32'(i);
        for (int i = 0; i < NB; i++) b_data[i] = 32'h200 + 32'(i);
        m_locked = 0; m_rr = 0; m_lock = 0; m_ptr = 0;
        m_ov = 0; m_ol = 0; m_oc = 0; m_od = 0; m_acc = 0;

        // Reset held two cycles with everything valid.
        add(1, 8'hff, 8'hff, 0, 0, 1, 8'h00, 0, 0);
        add(1, 8'hff, 8'hff, 0, 0, 1, 8'h00, 0, 0);
        // Round-robin fairness: 0..7 then 0 again.
        for (int k = 0; k < 9; k++) add(0, 8'hff, 8'hff, 0, 0, 1, 8'(1 << (k % 8)), 1, k % 8);
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 0);
        // Packet lock on ch2 with ch5 waiting; ptr lands on 3 (ch0 loses to ch5).
        add(0, 8'h24, 8'h00, 0, 0, 1, 8'h04, 1, 2);
        add(0, 8'h24, 8'h00, 0, 0, 1, 8'h04, 1, 2);
        add(0, 8'h24, 8'h04, 0, 0, 1, 8'h04, 1, 2);
        add(0, 8'h21, 8'h21, 0, 0, 1, 8'h20, 1, 5);
        add(0, 8'h01, 8'h01, 0, 0, 1, 8'h01, 1, 0);
        // Back-pressure for four cycles mid-stream.
        add(0, 8'hff, 8'hff, 0, 0, 1, 8'h02, 1, 1);
        for (int k = 0; k < 4; k++) add(0, 8'hff, 8'hff, 0, 0, 0, 8'h00, 1, 1);
        add(0, 8'hff, 8'hff, 0, 0, 1, 8'h04, 1, 2);
        // Forced select; forced packets leave ptr alone; lock ignores force.
        add(0, 8'h42, 8'h40, 1, 6, 1, 8'h40, 1, 6);
        add(0, 8'h42, 8'h42, 0, 0, 1, 8'h40, 1, 6);
        add(0, 8'h42, 8'h00, 1, 1, 1, 8'h02, 1, 1);
        add(0, 8'h42, 8'h02, 1, 6, 1, 8'h02, 1, 1);
        add(0, 8'h42, 8'h42, 0, 0, 1, 8'h02, 1, 1);
        add(0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 1);
        // Locked channel drops valid: nobody else gets in.
        add(0, 8'h24, 8'h00, 0, 0, 1, 8'h04, 1, 2);
        add(0, 8'h20, 8'h00, 0, 0, 1, 8'h00, 0, 2);
        add(0, 8'h24, 8'h04, 0, 0, 1, 8'h04, 1, 2);
        // Forced channel not valid: no grant.
        add(0, 8'h42, 8'h00, 1, 3, 1, 8'h00, 0, 2);

        @(posedge clk);
        #1;
        for (int n = 0; n < tq.size(); n++) begin
            a_rst = tq[n].rst; a_valid = tq[n].valid; a_last = tq[n].last;
            a_fen = tq[n].fen; a_fsel = tq[n].fsel; a_ordy = tq[n].ordy;
            tick_a(1, tq[n].rdy, tq[n].ov, tq[n].oc,
                   tq[n].rst ? 32'h0 : 32'h100 + 32'(tq[n].oc));
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            a_rst = ($urandom_range(63) == 0);
            for (int i = 0; i < NA; i++) begin
                a_data[i] = $urandom;
                a_last[i] = ($urandom_range(2) == 0);
            end
            a_valid = 8'($urandom);
            a_fen   = ($urandom_range(7) == 0);
            a_fsel  = 3'($urandom_range(7));
            a_ordy  = ($urandom_range(3) != 0);
            tick_a(0, 8'h00, 0, 0, 32'h0);
        end
        a_rst = 1;

        // 5 channels: out-of-range force, mid-packet reset, explicit wrap.
        tick_b(1, 5'h1f, 5'h1f, 0, 0, 5'h00, 0, 0, 1);
        tick_b(0, 5'h1f, 5'h1f, 1, 7, 5'h00, 0, 0, 1);
        tick_b(0, 5'h08, 5'h08, 0, 0, 5'h08, 1, 3, 0);
        tick_b(0, 5'h10, 5'h00, 0, 0, 5'h10, 1, 4, 0);
        tick_b(1, 5'h10, 5'h00, 0, 0, 5'h00, 0, 0, 1);
        tick_b(0, 5'h11, 5'h01, 0, 0, 5'h01, 1, 0, 0);
        tick_b(0, 5'h18, 5'h08, 0, 0, 5'h08, 1, 3, 0);
        tick_b(0, 5'h11, 5'h10, 0, 0, 5'h10, 1, 4, 0);
        tick_b(0, 5'h11, 5'h11, 0, 0, 5'h01, 1, 0, 0);
        tick_b(0, 5'h00, 5'h00, 0, 0, 5'h00, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule

// File: doc/arbitrated_multiplexer.md
# arbitrated_multiplexer

Parametrised N-channel stream multiplexer with a registered output, valid/ready handshakes per channel, and packet-locked round-robin arbitration with an optional forced-select mode. It sits between multiple producers and a single consumer in the core datapath (e.g. AES round-key / state / memory sources feeding one bus). It supersedes fixed-arity combinational muxes wherever back-pressure or multi-beat transfers exist.

## Interface
- WIDTH, 32, data width per channel
- CHANNELS, 8, number of input channels; must be at least 2, need not be a power of two
- SEL_W, $clog2(CHANNELS), channel index width (derived; not overridden)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_bus  in  CHANNELS*WIDTH  channel i data at bits [(CHANNELS-i)*WIDTH-1 -: WIDTH] (channel 0 most significant)
- in_valid  in  CHANNELS  bit i: channel i presents a beat
- in_last  in  CHANNELS  bit i: channel i's beat ends its packet
- in_ready  out  CHANNELS  bit i: channel i's beat is accepted this cycle (one-hot or zero)
- force_en  in  1  1: forced-select mode; 0: round-robin
- force_sel  in  SEL_W  channel granted when force_en=1
- out  out  WIDTH  registered data
- out_valid  out  1  registered beat present
- out_last  out  1  registered copy of accepted in_last
- out_channel  out  SEL_W  channel index of the registered beat
- out_ready  in  1  consumer accepts the output beat

## Operation
- Handshakes: a beat transfers when valid && ready on the same edge. Valid must not depend on ready.
- Output register: can load when !out_valid || out_ready (full throughput, no bubble). in_ready[g] = grant_valid && (g == grant) && load_ok, where load_ok = !out_valid || out_ready. in_ready is combinational from out_ready.
- Grant, state MUX_IDLE:
  - force_en=1: grant = force_sel if force_sel < CHANNELS and in_valid[force_sel]; otherwise no grant.
  - force_en=0: grant = first valid channel scanning from ptr upward, modulo CHANNELS.
- Grant, state MUX_LOCKED: grant = lock_ch only. force_en, force_sel and other valids are ignored.
- Transitions:
  - IDLE → LOCKED (lock_ch := grant) on an accepted beat with last=0.
  - LOCKED → IDLE on an accepted beat with last=1.
  - A last=1 beat accepted in IDLE stays IDLE.
- Round-robin pointer: ptr := (channel+1) mod CHANNELS when a last=1 beat is accepted, and only if that packet was started in round-robin mode. Packets started under force leave ptr unchanged. Wrap is explicit: ptr goes CHANNELS-1 → 0 even for non-power-of-two CHANNELS.
- On accept: out := in_bus slice of grant, out_last := in_last[grant], out_channel := grant, out_valid := 1.
- If out_valid && out_ready && no accept: out_valid := 0. Data fields hold their value.
- Reset (including mid-packet):
  - state := MUX_IDLE, ptr := 0, lock_ch := 0.
  - out_valid, out_last, out, out_channel := 0. Any held beat is discarded.
  - in_ready is forced to 0 while reset=1.

## Timing
- Latency: accepted input at edge n appears on out with out_valid=1 after edge n (1 cycle).
- Throughput: 1 beat/cycle sustained while out_ready=1.
- out_ready=0 with out_valid=1: all in_ready=0 and out, out_last, out_channel stay stable.
- Simultaneous pop and push in one cycle: new beat replaces old one, and out_valid stays 1.
- A grant change takes effect the same cycle in_valid or force_en changes in IDLE (combinational arbitration). The state/ptr update lands at the accepting edge.

## Structure
- Shared constants package: typedef enum logic {MUX_IDLE, MUX_LOCKED} mux_state_t.
- Sub-module rr_picker (combinational): inputs req[CHANNELS] and ptr; outputs grant index and grant_valid. Rotate-priority scan, parametrised on CHANNELS.
- Data selection instantiates the existing multiplexer module (WIDTH, CHANNELS, in_bus, sel, out) with sel=grant.
- Top holds the FSM, ptr, lock_ch, pointer-update mode bit and output register.

## Test plan
- Reset/idle: CHANNELS=8, hold reset 2 cycles with all in_valid=1 → in_ready=0; after release out_valid=0, out=0, out_channel=0.
- Round-robin fairness: all 8 channels valid, every last=1, out_ready=1, channel i data = 0x100+i → out_channel sequence 0,1,…,7,0 on consecutive cycles, 1-cycle latency.
- Packet lock: ch2 sends 3 beats (last on 3rd) while ch5 is valid → out_channel 2,2,2 then 5; ptr after ch2 packet = 3.
- Back-pressure: out_ready=0 for 4 cycles mid-stream → out stable, all in_ready=0; on release, no beat lost or duplicated (scoreboard).
- Forced mode: force_en=1, force_sel=6, ch6 and ch1 valid → only ch6 granted. Set force_sel=9 with CHANNELS=10? Invalid there; use CHANNELS=5, force_sel=7 → no grant.
- Mid-packet reset and wrap: CHANNELS=5, lock on ch4, assert reset for 1 cycle → IDLE, held beat gone. Then ch4 packet ends → next grant scan starts at ch0.
